// File: rtl/lynxTypes.sv
// Shared types and defaults for the CDMA request arbiter.
package lynxTypes;

  localparam int unsigned CDMA_ARB_N_REQ    = 4;
  localparam int unsigned CDMA_ARB_LEN_BITS = 28;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } cdma_arb_state_e;

endpackage

// File: rtl/cdma_arb_ord_fifo.sv
// Completion-order FIFO of requester ids; DEPTH must be a power of two.
module cdma_arb_ord_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_id_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_id_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && !full_o;
  assign head_id_o = mem_q[rd_q];
  assign count_o   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_id_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cdma_req_arb.sv
// Round-robin arbiter of N_REQ requesters onto one CDMA command channel.
// Optional CDMA_ARB_STATS_EN adds grant and stall counters.
module cdma_req_arb
  import lynxTypes::*;
#(
  parameter int unsigned N_REQ      = CDMA_ARB_N_REQ,
  parameter int unsigned ADDR_BITS  = 64,
  parameter int unsigned LEN_BITS   = CDMA_ARB_LEN_BITS,
  parameter int unsigned OUTS_DEPTH = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_REQ-1:0]          s_req_valid,
  output logic [N_REQ-1:0]          s_req_ready,
  input  logic [N_REQ*ADDR_BITS-1:0] s_req_addr,
  input  logic [N_REQ*LEN_BITS-1:0]  s_req_len,
  output logic [N_REQ-1:0]          s_req_done,
  output logic                      m_cdma_valid,
  input  logic                      m_cdma_ready,
  output logic [ADDR_BITS-1:0]      m_cdma_addr,
  output logic [LEN_BITS-1:0]       m_cdma_len,
  input  logic                      m_cdma_done,
`ifdef CDMA_ARB_STATS_EN
  output logic [N_REQ*32-1:0]       stat_grants,
  output logic [31:0]               stat_stall,
`endif
  output logic                      err_unexp_done
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  cdma_arb_state_e        state_q, state_d;
  logic [ID_W-1:0]        gnt_q, gnt_d, rr_q, rr_d, pick_c;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [LEN_BITS-1:0]    len_q, len_d;
  logic [N_REQ-1:0]       done_q, done_d, ready_c;
  logic                   err_q, err_d, run_q;
  logic                   push_c, pop_c;
  logic [ID_W-1:0]        fifo_head;
  logic [$clog2(OUTS_DEPTH):0] fifo_cnt;
  logic                   fifo_empty, fifo_full;
  logic [ADDR_BITS-1:0]   addr_a [N_REQ];
  logic [LEN_BITS-1:0]    len_a  [N_REQ];

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
    assign addr_a[g] = s_req_addr[g*ADDR_BITS +: ADDR_BITS];
    assign len_a[g]  = s_req_len[g*LEN_BITS +: LEN_BITS];
  end

  assign s_req_ready    = ready_c;
  assign s_req_done     = done_q;
  assign m_cdma_valid   = (state_q == ARB_ISSUE);
  assign m_cdma_addr    = addr_q;
  assign m_cdma_len     = len_q;
  assign err_unexp_done = err_q;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    int  idx;
    logic found;
    pick_c = rr_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (!found && s_req_valid[ID_W'(idx)]) begin
        pick_c = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    ready_c = '0;
    push_c  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // run_q keeps ready low while reset is asserted.
        if (run_q && (|s_req_valid) && !fifo_full) begin
          state_d         = ARB_ISSUE;
          gnt_d           = pick_c;
          ready_c[pick_c] = 1'b1;
          addr_d          = addr_a[pick_c];
          len_d           = len_a[pick_c];
        end
      end
      ARB_ISSUE: begin
        if (m_cdma_ready) begin
          push_c  = 1'b1;
          rr_d    = (gnt_q == ID_W'(N_REQ-1)) ? '0 : gnt_q + ID_W'(1);
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    pop_c  = m_cdma_done && !fifo_empty;
    done_d = '0;
    if (pop_c) done_d[fifo_head] = 1'b1;
    err_d  = err_q | (m_cdma_done & fifo_empty);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  // Grant reserves a slot, so the ISSUE push can never find the FIFO full.
  cdma_arb_ord_fifo #(
    .WIDTH (ID_W),
    .DEPTH (OUTS_DEPTH)
  ) u_ord_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push_i    (push_c),
    .push_id_i (gnt_q),
    .pop_i     (pop_c),
    .head_id_o (fifo_head),
    .count_o   (fifo_cnt),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

`ifdef CDMA_ARB_STATS_EN
  logic [31:0] stall_q;

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_stat
    logic [31:0] grants_q;
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)        grants_q <= '0;
      else if (ready_c[g]) grants_q <= grants_q + 32'd1;
    end
    assign stat_grants[g*32 +: 32] = grants_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) stall_q <= '0;
    else if ((state_q == ARB_IDLE) && (|s_req_valid) && fifo_full)
      stall_q <= stall_q + 32'd1;
  end
  assign stat_stall = stall_q;
`else
  logic unused_fifo_cnt;
  assign unused_fifo_cnt = ^fifo_cnt;
`endif

endmodule

// File: tb/tb_cdma_req_arb.sv
// Directed self-checking bench for cdma_req_arb (default parameters).
module tb_cdma_req_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned AB = 64;
  localparam int unsigned LB = 28;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    s_req_valid;
  logic [N-1:0]    s_req_ready;
  logic [N*AB-1:0] s_req_addr;
  logic [N*LB-1:0] s_req_len;
  logic [N-1:0]    s_req_done;
  logic            m_cdma_valid, m_cdma_ready, m_cdma_done;
  logic [AB-1:0]   m_cdma_addr;
  logic [LB-1:0]   m_cdma_len;
  logic            err_unexp_done;
`ifdef CDMA_ARB_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_stall;
`endif

  logic [AB-1:0] t_addr [N];
  logic [LB-1:0] t_len  [N];

  for (genvar g = 0; g < int'(N); g++) begin : g_pack
    assign s_req_addr[g*AB +: AB] = t_addr[g];
    assign s_req_len[g*LB +: LB]  = t_len[g];
  end

  always #5 aclk = ~aclk;

  cdma_req_arb dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_req_valid    (s_req_valid),
    .s_req_ready    (s_req_ready),
    .s_req_addr     (s_req_addr),
    .s_req_len      (s_req_len),
    .s_req_done     (s_req_done),
    .m_cdma_valid   (m_cdma_valid),
    .m_cdma_ready   (m_cdma_ready),
    .m_cdma_addr    (m_cdma_addr),
    .m_cdma_len     (m_cdma_len),
    .m_cdma_done    (m_cdma_done),
`ifdef CDMA_ARB_STATS_EN
    .stat_grants    (stat_grants),
    .stat_stall     (stat_stall),
`endif
    .err_unexp_done (err_unexp_done)
  );

  int checks   = 0;
  int failures = 0;
  int gnt_log [$];
  int out_cnt  = 0;
  int hs_cnt   = 0;
  bit auto_done = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Logs the handshakes about to happen at the next edge, then moves to the next negedge.
  task automatic step();
    int hs, dn;
    if (auto_done) m_cdma_done = (out_cnt > 0);
    #1;
    for (int i = 0; i < int'(N); i++) if (s_req_ready[i]) gnt_log.push_back(i);
    hs = (m_cdma_valid && m_cdma_ready) ? 1 : 0;
    dn = (m_cdma_done && out_cnt > 0) ? 1 : 0;
    hs_cnt  += hs;
    out_cnt += hs - dn;
    @(negedge aclk);
  endtask

  task automatic clear_inputs();
    s_req_valid  = '0;
    m_cdma_ready = 1'b0;
    m_cdma_done  = 1'b0;
    auto_done    = 1'b0;
    out_cnt      = 0;
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_m_valid"}, 64'(m_cdma_valid), 64'd0);
    check_eq({pfx, "_m_addr"},  64'(m_cdma_addr),  64'd0);
    check_eq({pfx, "_m_len"},   64'(m_cdma_len),   64'd0);
    check_eq({pfx, "_ready"},   64'(s_req_ready),  64'd0);
    check_eq({pfx, "_done"},    64'(s_req_done),   64'd0);
    check_eq({pfx, "_err"},     64'(err_unexp_done), 64'd0);
  endtask

  task automatic do_reset(input string pfx);
    aresetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge aclk);
    check_reset_state(pfx);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic drain();
    auto_done = 1'b1;
    step();
    step();
    for (int k = 0; k < 40 && out_cnt > 0; k++) step();
    check_eq("drain_outstanding", 64'(out_cnt), 64'd0);
    auto_done   = 1'b0;
    m_cdma_done = 1'b0;
    step();
  endtask

  initial begin
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    int base;
    for (int i = 0; i < int'(N); i++) begin
      t_addr[i] = 64'h2000 + 64'(i) * 64'h100;
      t_len[i]  = 28'h10 + 28'(i);
    end

    // Single requester 2 command and its completion.
    do_reset("rst0");
    t_addr[2] = 64'h1000;
    t_len[2]  = 28'h40;
    m_cdma_ready = 1'b1;
    s_req_valid  = 4'b0100;
    #1;
    check_eq("t1_ready", 64'(s_req_ready), 64'h4);
    step();
    check_eq("t1_m_valid", 64'(m_cdma_valid), 64'd1);
    check_eq("t1_m_addr",  64'(m_cdma_addr), 64'h1000);
    check_eq("t1_m_len",   64'(m_cdma_len),  64'h40);
    check_eq("t1_ready_issue", 64'(s_req_ready), 64'd0);
    s_req_valid = '0;
    step();
    check_eq("t1_m_valid_off", 64'(m_cdma_valid), 64'd0);
    check_eq("t1_one_cmd", 64'(hs_cnt), 64'd1);
    m_cdma_done = 1'b1;
    step();
    m_cdma_done = 1'b0;
    check_eq("t1_done2", 64'(s_req_done), 64'h4);
    step();
    check_eq("t1_done_pulse", 64'(s_req_done), 64'd0);

    // All requesters valid: round-robin order from pointer 0.
    do_reset("rst1");
    m_cdma_ready = 1'b1;
    auto_done    = 1'b1;
    gnt_log.delete();
    s_req_valid  = 4'b1111;
`ifdef CDMA_ARB_STATS_EN
    for (int k = 0; k < 1200 && gnt_log.size() < 400; k++) step();
`else
    for (int k = 0; k < 30 && gnt_log.size() < 5; k++) step();
`endif
    s_req_valid = '0;
    check_eq("t2_grant_cnt_min", 64'(gnt_log.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("t2_order%0d", i), 64'(gnt_log.size() > i ? gnt_log[i] : -1), 64'(exp_seq[i]));
    drain();
    check_eq("t2_err", 64'(err_unexp_done), 64'd0);
`ifdef CDMA_ARB_STATS_EN
    for (int i = 0; i < int'(N); i++)
      check_eq($sformatf("t2_stat_grants%0d", i), 64'(stat_grants[i*32 +: 32]), 64'd100);
    check_eq("t2_stat_stall", 64'(stat_stall), 64'd0);
`endif

    // Outstanding limit: ninth command stalls until one completion.
    gnt_log.delete();
    m_cdma_ready = 1'b1;
    s_req_valid  = 4'b0010;
    repeat (20) step();
    check_eq("t3_grants8", 64'(gnt_log.size()), 64'd8);
    #1;
    check_eq("t3_stall_ready", 64'(s_req_ready), 64'd0);
    check_eq("t3_stall_m_valid", 64'(m_cdma_valid), 64'd0);
    m_cdma_done = 1'b1;
    step();
    m_cdma_done = 1'b0;
    check_eq("t3_done1", 64'(s_req_done), 64'h2);
    for (int k = 0; k < 2 && gnt_log.size() < 9; k++) step();
    check_eq("t3_ninth", 64'(gnt_log.size()), 64'd9);
    s_req_valid = '0;
    drain();

    // Completion order follows command order 3, 0, 2.
    m_cdma_ready = 1'b1;
    s_req_valid = 4'b1000; step(); s_req_valid = '0; step();
    s_req_valid = 4'b0001; step(); s_req_valid = '0; step();
    s_req_valid = 4'b0100; step(); s_req_valid = '0; step();
    check_eq("t4_outstanding", 64'(out_cnt), 64'd3);
    m_cdma_done = 1'b1;
    step(); check_eq("t4_done_a", 64'(s_req_done), 64'h8);
    step(); check_eq("t4_done_b", 64'(s_req_done), 64'h1);
    step(); check_eq("t4_done_c", 64'(s_req_done), 64'h4);
    m_cdma_done = 1'b0;
    step(); check_eq("t4_done_idle", 64'(s_req_done), 64'd0);

    // Unexpected completion is sticky and produces no done pulse.
    m_cdma_done = 1'b1;
    step();
    m_cdma_done = 1'b0;
    check_eq("t5_err_set", 64'(err_unexp_done), 64'd1);
    check_eq("t5_no_done", 64'(s_req_done), 64'd0);
    step();
    check_eq("t5_err_sticky", 64'(err_unexp_done), 64'd1);

    // Reset while one command is outstanding and another is held in ISSUE.
    m_cdma_ready = 1'b1;
    s_req_valid = 4'b0001; step(); s_req_valid = '0; step();
    t_addr[1]    = 64'hABCD_0000;
    m_cdma_ready = 1'b0;
    s_req_valid  = 4'b0010;
    step();
    s_req_valid = '0;
    check_eq("t5_issue_valid", 64'(m_cdma_valid), 64'd1);
    check_eq("t5_issue_addr",  64'(m_cdma_addr), 64'hABCD_0000);
    #2 aresetn = 1'b0;
    #1;
    check_eq("t5_async_m_valid", 64'(m_cdma_valid), 64'd0);
    check_reset_state("t5_async");
    clear_inputs();
    s_req_valid = 4'b1111;
    @(negedge aclk);
    check_eq("t5_rst_ready", 64'(s_req_ready), 64'd0);
    aresetn = 1'b1;
    step();
    check_eq("t5_ptr_zero", 64'(s_req_ready), 64'h1);
    s_req_valid = '0;
    step();
    m_cdma_done = 1'b1;
    step();
    m_cdma_done = 1'b0;
    check_eq("t5_no_stale_done", 64'(s_req_done), 64'd0);
    check_eq("t5_stale_err", 64'(err_unexp_done), 64'd1);
    base = hs_cnt;
    step();
    check_eq("t5_no_cmd", 64'(hs_cnt - base), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdma_req_arb.md
CDMA_REQ_ARB -- requirements
Module: cdma_req_arb

Interface
- REQ-001 Parameter N_REQ, 4, number of requesters sharing one CDMA command channel (2..16).
- REQ-002 Parameter ADDR_BITS, 64, command address width.
- REQ-003 Parameter LEN_BITS, 28, command length width (bytes).
- REQ-004 Parameter OUTS_DEPTH, 8, maximum outstanding commands (power of two).
- REQ-005 aclk  in  1  single clock; all logic in this domain.
- REQ-006 aresetn  in  1  reset, asynchronous, active-low.
- REQ-007 s_req_valid  in  N_REQ  per-requester command valid.
- REQ-008 s_req_ready  out  N_REQ  per-requester command accepted.
- REQ-009 s_req_addr  in  N_REQ*ADDR_BITS  packed addresses, requester i at slice i.
- REQ-010 s_req_len  in  N_REQ*LEN_BITS  packed lengths.
- REQ-011 s_req_done  out  N_REQ  one-cycle completion pulse to requester.
- REQ-012 m_cdma_valid / m_cdma_ready  out / in  1 / 1  CDMA command handshake.
- REQ-013 m_cdma_addr / m_cdma_len  out  ADDR_BITS / LEN_BITS  granted command.
- REQ-014 m_cdma_done  in  1  CDMA completion pulse, in command order.
- REQ-015 err_unexp_done  out  1  sticky: done received with nothing outstanding.

Function
- REQ-016 FSM states IDLE, ISSUE; IDLE->ISSUE when any s_req_valid set and outstanding count < OUTS_DEPTH.
- REQ-017 In IDLE, grant the lowest-index valid requester at or after the round-robin pointer (wrapping), latch its addr/len and id, pulse its s_req_ready for exactly that cycle.
- REQ-018 In ISSUE, m_cdma_valid held 1 with stable addr/len until m_cdma_ready; on handshake push granted id to the order FIFO, move pointer to grant+1 mod N_REQ, return to IDLE.
- REQ-019 Back-to-back throughput: one command per 2 cycles minimum.
- REQ-020 No grant while order FIFO full (count = OUTS_DEPTH); requesters stall with s_req_ready 0.
- REQ-021 On m_cdma_done, pop FIFO head id and assert s_req_done[id] on the next cycle (latency 1).
- REQ-022 Simultaneous push and pop in one cycle: count unchanged, both take effect; full FIFO with simultaneous pop does not enable the push beyond depth (push occurs only from ISSUE, already reserved).
- REQ-023 Outstanding count includes the command held in ISSUE (reserved at grant) so FIFO never overflows.
- REQ-024 m_cdma_done with FIFO empty: no s_req_done, set err_unexp_done until reset.
- REQ-025 A requester dropping s_req_valid before grant is legal; no pointer change.

Reset
- REQ-026 On aresetn low: state IDLE, pointer 0, FIFO empty, count 0, s_req_ready 0, s_req_done 0, m_cdma_valid 0, m_cdma_addr/len 0, err_unexp_done 0.
- REQ-027 Reset mid-ISSUE or with outstanding commands discards them; no done pulses after release for pre-reset commands.

Configuration
- REQ-028 Macro CDMA_ARB_STATS_EN: when defined, adds output stat_grants (N_REQ*32, per-requester accepted-command counters, wrapping) and stat_stall (32, cycles with valid request blocked by full FIFO), reset to 0.
- REQ-029 Without CDMA_ARB_STATS_EN the stat ports and counters do not exist; all other behaviour identical.

Structure
- REQ-030 Shared package lynxTypes holds CDMA_ARB_N_REQ default, LEN_BITS default and the FSM state typedef.
- REQ-031 One sub-module cdma_arb_ord_fifo (id FIFO, width clog2(N_REQ), depth OUTS_DEPTH, count output).

Verification
- REQ-032 Single requester 2, addr 0x1000 len 0x40, ready tied 1 -> m_cdma_addr 0x1000 len 0x40 one command; s_req_done[2] one cycle after m_cdma_done.
- REQ-033 All 4 requesters valid continuously, ready 1 -> grants in order 0,1,2,3,0; each stat_grants equal after 400 commands (stats build).
- REQ-034 Requester 1 issues 8 commands, no done -> 9th stalls, s_req_ready 0; one m_cdma_done -> 9th accepted within 2 cycles.
- REQ-035 Commands from ids 3,0,2 outstanding; 3 done pulses -> s_req_done order 3,0,2.
- REQ-036 m_cdma_done with nothing outstanding -> err_unexp_done 1, no s_req_done; aresetn low mid-ISSUE -> m_cdma_valid 0 asynchronously, all state per REQ-026.
